// File: rtl/frame_info_fifo.sv
// Purpose: DEPTH-entry ring of per-frame info records, with geometry stability qualification.
// Latency: capture visible on head outputs one cycle after the capture edge; pop advances head in one cycle.
// Backpressure: none upstream; a push into a full ring overwrites the oldest entry and sets sticky O_overflow.
module frame_info_fifo #(
    parameter int MAX_WIDTH     = 1920,
    parameter int MAX_HEIGHT    = 1080,
    parameter int DEPTH         = 4,
    parameter int STABLE_FRAMES = 3,
    localparam int WW = $clog2(MAX_WIDTH),
    localparam int HW = $clog2(MAX_HEIGHT),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          I_clk,
    input  logic          I_rst_n,
    input  logic          I_capture,
    input  logic [WW-1:0] I_image_width,
    input  logic [HW-1:0] I_image_height,
    input  logic          I_image_valid,
    input  logic          I_hs_detected,
    input  logic          I_vs_detected,
    input  logic          I_rd_en,
    input  logic          I_clear_overflow,
    output logic          O_rd_valid,
    output logic [WW-1:0] O_image_width,
    output logic [HW-1:0] O_image_height,
    output logic          O_image_valid,
    output logic          O_hs_detected,
    output logic          O_vs_detected,
    output logic [7:0]    O_frame_id,
    output logic          O_stable,
    output logic          O_changed,
    output logic [AW:0]   O_count,
    output logic          O_overflow
);

    typedef struct packed {
        logic [WW-1:0] width;
        logic [HW-1:0] height;
        logic          valid;
        logic          hs;
        logic          vs;
        logic [7:0]    frame_id;
        logic          stable;
        logic          changed;
    } entry_t;

    localparam logic [AW:0] FULL_C   = (AW+1)'(DEPTH);
    localparam logic [3:0]  STABLE_C = 4'(STABLE_FRAMES);

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    entry_t        head_q, head_d;
    entry_t        new_entry;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    frame_id_q, frame_id_d;
    logic [3:0]    stab_cnt_q, stab_cnt_d;
    logic          first_q, first_d;
    logic [WW-1:0] prev_width_q, prev_width_d;
    logic [HW-1:0] prev_height_q, prev_height_d;
    logic          prev_valid_q, prev_valid_d;

    logic          geom_match;
    logic          do_pop;
    logic          ovf_event;

    // Build the record for this capture and advance frame ID / stability tracking.
    always_comb begin
        frame_id_d    = frame_id_q;
        stab_cnt_d    = stab_cnt_q;
        first_d       = first_q;
        prev_width_d  = prev_width_q;
        prev_height_d = prev_height_q;
        prev_valid_d  = prev_valid_q;
        // hs/vs deliberately excluded: sync flags may flicker without a geometry change
        geom_match    = !first_q
                        && (I_image_width  == prev_width_q)
                        && (I_image_height == prev_height_q)
                        && (I_image_valid  == prev_valid_q);
        new_entry     = '0;
        if (I_capture) begin
            if (geom_match) begin
                stab_cnt_d = (stab_cnt_q >= STABLE_C) ? STABLE_C : stab_cnt_q + 4'd1;
            end else begin
                stab_cnt_d = 4'd1;
            end
            frame_id_d    = frame_id_q + 8'd1;
            first_d       = 1'b0;
            prev_width_d  = I_image_width;
            prev_height_d = I_image_height;
            prev_valid_d  = I_image_valid;
        end
        new_entry.width    = I_image_width;
        new_entry.height   = I_image_height;
        new_entry.valid    = I_image_valid;
        new_entry.hs       = I_hs_detected;
        new_entry.vs       = I_vs_detected;
        new_entry.frame_id = frame_id_q;
        new_entry.stable   = (stab_cnt_d >= STABLE_C) && I_image_valid;
        new_entry.changed  = !geom_match;
    end

    // Ring pointer/count update, overflow tracking and registered head selection.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_event  = 1'b0;
        // pop on an empty ring is ignored, including when a push arrives the same cycle
        do_pop     = I_rd_en && (count_q != '0);
        if (I_capture) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (I_capture && do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else if (I_capture) begin
            if (count_q == FULL_C) begin
                // keep the newest data: drop the oldest entry
                rd_ptr_d  = rd_ptr_q + 1'b1;
                ovf_event = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end
        // set wins over clear when both happen together
        if (ovf_event) begin
            overflow_d = 1'b1;
        end else if (I_clear_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        // head holds the last popped entry once the ring drains
        head_d = (count_d != '0) ? mem_d[rd_ptr_d] : head_q;
    end

    // State registers; history (frame ID, stability, previous geometry) only clears on reset.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            frame_id_q    <= '0;
            stab_cnt_q    <= '0;
            first_q       <= 1'b1;
            prev_width_q  <= '0;
            prev_height_q <= '0;
            prev_valid_q  <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            head_q        <= head_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            frame_id_q    <= frame_id_d;
            stab_cnt_q    <= stab_cnt_d;
            first_q       <= first_d;
            prev_width_q  <= prev_width_d;
            prev_height_q <= prev_height_d;
            prev_valid_q  <= prev_valid_d;
        end
    end

    assign O_rd_valid     = (count_q != '0);
    assign O_count        = count_q;
    assign O_overflow     = overflow_q;
    assign O_image_width  = head_q.width;
    assign O_image_height = head_q.height;
    assign O_image_valid  = head_q.valid;
    assign O_hs_detected  = head_q.hs;
    assign O_vs_detected  = head_q.vs;
    assign O_frame_id     = head_q.frame_id;
    assign O_stable       = head_q.stable;
    assign O_changed      = head_q.changed;

endmodule

// File: tb/tb_frame_info_fifo.sv
// Purpose: directed self-checking bench for frame_info_fifo (DEPTH=4, STABLE_FRAMES=3).
// Latency: drives inputs 1ns after the rising edge and samples 1ns after the following edge.
// Backpressure: exercises overflow, simultaneous push/pop, and pop on empty.
module tb_frame_info_fifo;

    localparam int WW = 11;
    localparam int HW = 11;
    localparam int AW = 2;

    logic          I_clk;
    logic          I_rst_n;
    logic          I_capture;
    logic [WW-1:0] I_image_width;
    logic [HW-1:0] I_image_height;
    logic          I_image_valid;
    logic          I_hs_detected;
    logic          I_vs_detected;
    logic          I_rd_en;
    logic          I_clear_overflow;
    logic          O_rd_valid;
    logic [WW-1:0] O_image_width;
    logic [HW-1:0] O_image_height;
    logic          O_image_valid;
    logic          O_hs_detected;
    logic          O_vs_detected;
    logic [7:0]    O_frame_id;
    logic          O_stable;
    logic          O_changed;
    logic [AW:0]   O_count;
    logic          O_overflow;

    int checks;
    int failures;

    frame_info_fifo #(
        .MAX_WIDTH(1920), .MAX_HEIGHT(1080), .DEPTH(4), .STABLE_FRAMES(3)
    ) dut (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .I_capture(I_capture),
        .I_image_width(I_image_width), .I_image_height(I_image_height),
        .I_image_valid(I_image_valid), .I_hs_detected(I_hs_detected),
        .I_vs_detected(I_vs_detected), .I_rd_en(I_rd_en),
        .I_clear_overflow(I_clear_overflow), .O_rd_valid(O_rd_valid),
        .O_image_width(O_image_width), .O_image_height(O_image_height),
        .O_image_valid(O_image_valid), .O_hs_detected(O_hs_detected),
        .O_vs_detected(O_vs_detected), .O_frame_id(O_frame_id),
        .O_stable(O_stable), .O_changed(O_changed), .O_count(O_count),
        .O_overflow(O_overflow)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock: apply controls, take the edge, return 1ns later with strobes cleared.
    task automatic step(input logic cap, input logic rd, input logic clr,
                        input logic [WW-1:0] w, input logic [HW-1:0] h, input logic v);
        I_capture        = cap;
        I_rd_en          = rd;
        I_clear_overflow = clr;
        I_image_width    = w;
        I_image_height   = h;
        I_image_valid    = v;
        I_hs_detected    = cap;
        I_vs_detected    = 1'b1;
        @(posedge I_clk);
        #1;
        I_capture        = 1'b0;
        I_rd_en          = 1'b0;
        I_clear_overflow = 1'b0;
    endtask

    task automatic cap_fhd();  step(1'b1, 1'b0, 1'b0, 11'd1920, 11'd1080, 1'b1); endtask
    task automatic cap_hd();   step(1'b1, 1'b0, 1'b0, 11'd1280, 11'd720,  1'b1); endtask
    task automatic pop();      step(1'b0, 1'b1, 1'b0, 11'd0,    11'd0,    1'b0); endtask

    task automatic head(input string tag, input int id, input int w, input int chg, input int stb);
        check({tag, ".valid"}, 32'(O_rd_valid), 32'd1);
        check({tag, ".id"},    32'(O_frame_id), 32'(id));
        check({tag, ".width"}, 32'(O_image_width), 32'(w));
        check({tag, ".chg"},   32'(O_changed), 32'(chg));
        check({tag, ".stb"},   32'(O_stable), 32'(stb));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        I_rst_n = 1'b0;
        I_capture = 1'b0; I_rd_en = 1'b0; I_clear_overflow = 1'b0;
        I_image_width = '0; I_image_height = '0; I_image_valid = 1'b0;
        I_hs_detected = 1'b0; I_vs_detected = 1'b0;
        #12;
        check("rst.rd_valid", 32'(O_rd_valid), 32'd0);
        check("rst.count",    32'(O_count), 32'd0);
        check("rst.ovf",      32'(O_overflow), 32'd0);
        check("rst.width",    32'(O_image_width), 32'd0);
        check("rst.id",       32'(O_frame_id), 32'd0);
        @(posedge I_clk); #1;
        I_rst_n = 1'b1;
        @(posedge I_clk); #1;

        // three identical 1080p captures then drain
        cap_fhd();
        check("t1.count1", 32'(O_count), 32'd1);
        head("t1.first", 0, 1920, 1, 0);
        check("t1.height", 32'(O_image_height), 32'd1080);
        cap_fhd();
        cap_fhd();
        check("t1.count3", 32'(O_count), 32'd3);
        pop();
        head("t1.pop1", 1, 1920, 0, 0);
        pop();
        head("t1.pop2", 2, 1920, 0, 1);
        check("t1.count1b", 32'(O_count), 32'd1);
        pop();
        check("t1.empty", 32'(O_rd_valid), 32'd0);
        check("t1.count0", 32'(O_count), 32'd0);
        check("t1.hold.id", 32'(O_frame_id), 32'd2);

        // geometry change restarts qualification
        cap_fhd();  // id3 stable
        cap_hd();   // id4 changed
        cap_hd();   // id5
        cap_hd();   // id6 stable
        check("t2.count4", 32'(O_count), 32'd4);
        head("t2.id3", 3, 1920, 0, 1);
        pop();
        head("t2.id4", 4, 1280, 1, 0);
        check("t2.height", 32'(O_image_height), 32'd720);
        pop();
        head("t2.id5", 5, 1280, 0, 0);
        pop();
        head("t2.id6", 6, 1280, 0, 1);
        pop();
        check("t2.empty", 32'(O_rd_valid), 32'd0);

        // six captures into a four-deep ring: ids 7..12 kept 9..12
        for (int k = 0; k < 4; k++) cap_hd();
        check("t3.ovf.pre", 32'(O_overflow), 32'd0);
        cap_hd();
        check("t3.ovf.rise", 32'(O_overflow), 32'd1);
        check("t3.head8", 32'(O_frame_id), 32'd8);
        cap_hd();
        check("t3.count", 32'(O_count), 32'd4);
        check("t3.head9", 32'(O_frame_id), 32'd9);
        for (int k = 9; k <= 12; k++) begin
            check("t3.pop.id", 32'(O_frame_id), 32'(k));
            pop();
        end
        check("t3.empty", 32'(O_rd_valid), 32'd0);
        check("t3.ovf.sticky", 32'(O_overflow), 32'd1);
        step(1'b0, 1'b0, 1'b1, 11'd0, 11'd0, 1'b0);
        check("t3.ovf.clr", 32'(O_overflow), 32'd0);

        // full ring with simultaneous push and pop: ids 13..16 then 17
        for (int k = 0; k < 4; k++) cap_hd();
        check("t4.head13", 32'(O_frame_id), 32'd13);
        step(1'b1, 1'b1, 1'b0, 11'd1280, 11'd720, 1'b1);
        check("t4.count", 32'(O_count), 32'd4);
        check("t4.ovf", 32'(O_overflow), 32'd0);
        check("t4.head14", 32'(O_frame_id), 32'd14);
        // overflow coincident with clear: set wins (id18)
        step(1'b1, 1'b0, 1'b1, 11'd1280, 11'd720, 1'b1);
        check("t4.setwins", 32'(O_overflow), 32'd1);
        check("t4.head15", 32'(O_frame_id), 32'd15);
        for (int k = 15; k <= 18; k++) begin
            check("t4.pop.id", 32'(O_frame_id), 32'(k));
            pop();
        end
        check("t4.count0", 32'(O_count), 32'd0);

        // empty ring with simultaneous push and pop: id19
        step(1'b1, 1'b1, 1'b0, 11'd640, 11'd480, 1'b1);
        check("t5.count", 32'(O_count), 32'd1);
        head("t5.new", 19, 640, 1, 0);
        pop();
        check("t5.empty", 32'(O_rd_valid), 32'd0);

        // frame ID wrap 255 -> 0 with interleaved pops
        for (int k = 20; k <= 257; k++) begin
            cap_hd();
            check("t6.id", 32'(O_frame_id), 32'(k % 256));
            pop();
        end
        check("t6.empty", 32'(O_count), 32'd0);

        // asynchronous reset mid-stream, with overflow pending
        for (int k = 0; k < 5; k++) cap_hd();
        check("t7.ovf.pre", 32'(O_overflow), 32'd1);
        #3;
        I_rst_n = 1'b0;
        #1;
        check("t7.rd_valid", 32'(O_rd_valid), 32'd0);
        check("t7.count",    32'(O_count), 32'd0);
        check("t7.ovf",      32'(O_overflow), 32'd0);
        check("t7.id",       32'(O_frame_id), 32'd0);
        check("t7.width",    32'(O_image_width), 32'd0);
        check("t7.stable",   32'(O_stable), 32'd0);
        @(posedge I_clk); #1;
        I_rst_n = 1'b1;
        @(posedge I_clk); #1;
        cap_hd();
        check("t7.count1", 32'(O_count), 32'd1);
        head("t7.after", 0, 1280, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
